// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative right shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    // Bits moved per cycle on the wide step of the fast build.
    localparam int FAST_STEP = 4;

endpackage

// File: rtl/shift_right_step.sv
// One combinational right-shift step: by 1 bit, or by FAST_STEP bits when wide_step is set.
module shift_right_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             fill,
    input  logic             wide_step,
    output logic [WIDTH-1:0] shifted
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic narrow_bit;
            logic wide_bit;

            if (gi + 1 < WIDTH) begin : g_narrow_src
                assign narrow_bit = value[gi+1];
            end else begin : g_narrow_fill
                assign narrow_bit = fill;
            end

            if (gi + FAST_STEP < WIDTH) begin : g_wide_src
                assign wide_bit = value[gi+FAST_STEP];
            end else begin : g_wide_fill
                assign wide_bit = fill;
            end

            assign shifted[gi] = wide_step ? wide_bit : narrow_bit;
        end
    endgenerate

endmodule

// File: rtl/shift_right_iter.sv
// Iterative right shifter (logical/arithmetic), one bit per cycle.
// Define SHIFT_RIGHT_ITER_FAST_EN to move 4 bits per cycle while at least 4 remain.
module shift_right_iter
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t             state_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [SHAMT_W-1:0] remaining_reg;
    logic               fill_mode_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               wide_step;
    logic [SHAMT_W-1:0] step_amt;
    logic               fill_bit;
    logic [WIDTH-1:0]   shifted;

`ifdef SHIFT_RIGHT_ITER_FAST_EN
    assign wide_step = (remaining_reg >= SHAMT_W'(FAST_STEP));
`else
    assign wide_step = 1'b0;
`endif

    assign step_amt = wide_step ? SHAMT_W'(FAST_STEP) : SHAMT_W'(1);
    // The MSB never changes under sign fill, so it still holds the captured sign.
    assign fill_bit = fill_mode_reg & result_reg[WIDTH-1];

    shift_right_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value    (result_reg),
        .fill     (fill_bit),
        .wide_step(wide_step),
        .shifted  (shifted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            result_reg    <= '0;
            remaining_reg <= '0;
            fill_mode_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        result_reg    <= data_in;
                        remaining_reg <= shamt;
                        fill_mode_reg <= arith;
                        if (shamt != '0) begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end else begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                end
                SHIFT: begin
                    result_reg    <= shifted;
                    remaining_reg <= remaining_reg - step_amt;
                    if (remaining_reg == step_amt) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_shift_right_iter.sv
// Randomized self-checking bench for shift_right_iter against an arithmetic reference model.
module tb_shift_right_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic        arith;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int passes;

    shift_right_iter #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .arith  (arith),
        .data_in(data_in),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain shift operators on the whole operand.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input bit a);
        logic signed [31:0] sd;
        sd = d;
        if (a) return 32'(sd >>> s);
        return d >> s;
    endfunction

    // Spec latency: done is sampled high at edge k + latency.
    function automatic int exp_lat(input int s);
`ifdef SHIFT_RIGHT_ITER_FAST_EN
        return (s / 4) + (s % 4) + 1;
`else
        return s + 1;
`endif
    endfunction

    // Present a request; returns just after the accepting edge.
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a);
        @(negedge clk);
        data_in = d;
        shamt   = s;
        arith   = a;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done; lat is the spec latency (edges after the accepting edge until done is sampled).
    task automatic wait_done(output int lat, output logic [31:0] res, output int overlap, output bit busy_seen);
        int n;
        n = 0;
        overlap = 0;
        busy_seen = 1'b0;
        if (busy && done) overlap++;
        if (busy) busy_seen = 1'b1;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (busy && done) overlap++;
            if (busy) busy_seen = 1'b1;
        end
        lat = done ? n + 1 : -1;
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0)
            $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0/0/00000000", busy, done, result);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0/0", busy, done);
        else passes++;
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
    endtask

    task automatic test_directed();
        logic [31:0] res;
        int lat, ov;
        bit bs;

        issue(32'h8000_0000, 5'd4, 1'b0);
        wait_done(lat, res, ov, bs);
        $display("op logical d=80000000 s=4 result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'h0800_0000) $display("FAIL logical_result: got %h expected 08000000", res);
        else passes++;
        checks++;
        if (lat != exp_lat(4)) $display("FAIL logical_latency: got %0d expected %0d", lat, exp_lat(4));
        else passes++;

        issue(32'h8000_0000, 5'd31, 1'b1);
        wait_done(lat, res, ov, bs);
        $display("op arith d=80000000 s=31 result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'hFFFF_FFFF) $display("FAIL arith_result: got %h expected ffffffff", res);
        else passes++;
        checks++;
        if (lat != exp_lat(31)) $display("FAIL arith_latency: got %0d expected %0d", lat, exp_lat(31));
        else passes++;
        checks++;
        if (ov != 0) $display("FAIL arith_busy_done_overlap: got %0d expected 0", ov);
        else passes++;

        repeat (2) @(posedge clk);
        issue(32'h1234_5678, 5'd0, 1'b0);
        wait_done(lat, res, ov, bs);
        $display("op zero d=12345678 s=0 result=%h lat=%0d busy_seen=%b", res, lat, bs);
        checks++;
        if (res !== 32'h1234_5678) $display("FAIL zero_result: got %h expected 12345678", res);
        else passes++;
        checks++;
        if (lat != 1) $display("FAIL zero_latency: got %0d expected 1", lat);
        else passes++;
        checks++;
        if (bs !== 1'b0) $display("FAIL zero_busy: got busy_seen=%b expected 0", bs);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] d, res, exp;
        int s, lat, ov;
        bit a, bs;
        for (int i = 0; i < 24; i++) begin
            d = $urandom;
            if (i % 3 == 0) d[31] = 1'b1;
            s = $urandom_range(0, 31);
            a = 1'($urandom_range(0, 1));
            exp = ref_shift(d, s, a);
            issue(d, 5'(s), a);
            wait_done(lat, res, ov, bs);
            $display("op rand[%0d] d=%h s=%0d a=%0d result=%h lat=%0d", i, d, s, a, res, lat);
            checks++;
            if (res !== exp) $display("FAIL rand_result[%0d]: got %h expected %h", i, res, exp);
            else passes++;
            checks++;
            if (lat != exp_lat(s)) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(s));
            else passes++;
            checks++;
            if (ov != 0) $display("FAIL rand_busy_done_overlap[%0d]: got %0d expected 0", i, ov);
            else passes++;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, ov;
        bit bs;

        issue(32'h0000_0404, 5'd2, 1'b0);
        wait_done(lat, res, ov, bs);
        $display("op b2b_first d=00000404 s=2 result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'h0000_0101) $display("FAIL b2b_first_result: got %h expected 00000101", res);
        else passes++;
        checks++;
        if (lat != exp_lat(2)) $display("FAIL b2b_first_latency: got %0d expected %0d", lat, exp_lat(2));
        else passes++;

        // Still in the done cycle: request the next operation now.
        data_in = 32'hFFFF_FFF0;
        shamt   = 5'd4;
        arith   = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_no_gap: got busy=%b done=%b expected 1/0", busy, done);
        else passes++;
        wait_done(lat, res, ov, bs);
        $display("op b2b_second d=fffffff0 s=4 result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'hFFFF_FFFF) $display("FAIL b2b_second_result: got %h expected ffffffff", res);
        else passes++;
        checks++;
        if (lat != exp_lat(4)) $display("FAIL b2b_second_latency: got %0d expected %0d", lat, exp_lat(4));
        else passes++;
    endtask

    task automatic test_ignore_busy();
        logic [31:0] res;
        int lat, ov, extra_done;
        bit bs;

        issue(32'hF000_0000, 5'd8, 1'b0);
        @(posedge clk);
        #1;
        data_in = 32'h0000_0001;
        shamt   = 5'd1;
        arith   = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, res, ov, bs);
        lat = (lat < 0) ? lat : lat + 2;
        $display("op ignore_busy d=f0000000 s=8 result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'h00F0_0000) $display("FAIL ignore_result: got %h expected 00f00000", res);
        else passes++;
        checks++;
        if (lat != exp_lat(8)) $display("FAIL ignore_latency: got %0d expected %0d", lat, exp_lat(8));
        else passes++;
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        checks++;
        if (extra_done != 0 || result !== 32'h00F0_0000)
            $display("FAIL ignore_single_done: got extra_done=%0d result=%h expected 0 00f00000", extra_done, result);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat, ov;
        bit bs;

        issue(32'hDEAD_BEEF, 5'd20, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        $display("op reset_mid busy=%b done=%b result=%h", busy, done, result);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0)
            $display("FAIL reset_mid_clear: got busy=%b done=%b result=%h expected 0/0/00000000", busy, done, result);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(32'h0000_0002, 5'd1, 1'b0);
        wait_done(lat, res, ov, bs);
        $display("op after_reset d=00000002 s=1 result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'h0000_0001) $display("FAIL after_reset_result: got %h expected 00000001", res);
        else passes++;
        checks++;
        if (lat != exp_lat(1)) $display("FAIL after_reset_latency: got %0d expected %0d", lat, exp_lat(1));
        else passes++;
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        arith   = 1'b0;
        data_in = '0;
        shamt   = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
